// File: rtl/inv_transmission_pipe.sv
// Fully pipelined reciprocal 1/t (Q0.8 in, Q2.14 out) with a matched sideband delay line.
// Entry register S0 followed by 16 restoring-division stages; one pixel per clock.
module inv_transmission_pipe #(
  parameter int SB_W = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            in_valid,
  input  logic [7:0]      trans,
  input  logic [SB_W-1:0] in_sb,
  output logic            out_valid,
  output logic [15:0]     inv_trans,
  output logic [SB_W-1:0] out_sb
);

  // Handshake: a pixel is taken when in_valid=1 on a rising edge with stall=0;
  // there is no ready, so downstream must consume every out_valid=1 cycle.
  // stall freezes every stage (valid, data and sideband) together.

  localparam int NS = 17;

  logic [NS-1:0]            vld_q, vld_d;
  logic [NS-1:0]            sat_q, sat_d;
  logic [NS-1:0][15:0]      q_q, q_d;
  logic [NS-1:0][SB_W-1:0]  sb_q, sb_d;
  logic [NS-2:0][7:0]       d_q, d_d;
  logic [NS-2:0][8:0]       r_q, r_d;
  logic [NS-2:0]            ge_w;

  always_comb begin
    vld_d = vld_q;
    sat_d = sat_q;
    q_d   = q_q;
    sb_d  = sb_q;
    d_d   = d_q;
    r_d   = r_q;
    ge_w  = '0;

    // S0: the dividend 2^22 is represented by starting remainder 64 and 16 quotient bits
    vld_d[0] = in_valid;
    sat_d[0] = (trans <= 8'd64);
    q_d[0]   = '0;
    sb_d[0]  = in_sb;
    d_d[0]   = trans;
    r_d[0]   = 9'd64;

    for (int j = 0; j < NS - 1; j++) begin
      ge_w[j] = ({r_q[j], 1'b0} >= {2'b00, d_q[j]});
    end

    for (int k = 1; k < NS; k++) begin
      vld_d[k] = vld_q[k-1];
      sat_d[k] = sat_q[k-1];
      sb_d[k]  = sb_q[k-1];
      q_d[k]   = (q_q[k-1] << 1) | {15'd0, ge_w[k-1]};
    end

    // Remainder and divisor are only needed up to the stage feeding the last quotient bit
    for (int k = 1; k < NS - 1; k++) begin
      d_d[k] = d_q[k-1];
      if (ge_w[k-1]) begin
        r_d[k] = {r_q[k-1][7:0], 1'b0} - {1'b0, d_q[k-1]};
      end else begin
        r_d[k] = {r_q[k-1][7:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      sat_q <= '0;
      q_q   <= '0;
      sb_q  <= '0;
      d_q   <= '0;
      r_q   <= '0;
    end else if (!stall) begin
      vld_q <= vld_d;
      sat_q <= sat_d;
      q_q   <= q_d;
      sb_q  <= sb_d;
      d_q   <= d_d;
      r_q   <= r_d;
    end
  end

  assign out_valid = vld_q[NS-1];
  assign inv_trans = sat_q[NS-1] ? 16'hFFFF : q_q[NS-1];
  assign out_sb    = sb_q[NS-1];

endmodule

// File: tb/tb_inv_transmission_pipe.sv
// Self-checking bench for inv_transmission_pipe: randomized stimulus against a
// floor(2^22/t) model with a history of accepted slots indexed by active-edge count.
module tb_inv_transmission_pipe;

  localparam int SB_W = 24;
  localparam int LAT  = 17;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic            in_valid;
  logic [7:0]      trans;
  logic [SB_W-1:0] in_sb;
  logic            out_valid;
  logic [15:0]     inv_trans;
  logic [SB_W-1:0] out_sb;

  inv_transmission_pipe #(.SB_W(SB_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .in_valid  (in_valid),
    .trans     (trans),
    .in_sb     (in_sb),
    .out_valid (out_valid),
    .inv_trans (inv_trans),
    .out_sb    (out_sb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            v;
    logic [7:0]      t;
    logic [SB_W-1:0] sb;
  } pix_t;

  pix_t            hist[$];
  int              n_act;
  int              tests;
  int              fails;
  logic            exp_v;
  logic [15:0]     exp_inv;
  logic [SB_W-1:0] exp_sb;
  logic            chk_data;

  function automatic logic [15:0] inv_ref(input logic [7:0] t);
    if (t <= 8'd64) return 16'hFFFF;
    return 16'((32'd1 << 22) / {24'd0, t});
  endfunction

  // Drive one clock of inputs, advance the model, and leave expectations for the cycle after the edge.
  task automatic cycle(input logic r, input logic st, input logic v,
                       input logic [7:0] t, input logic [SB_W-1:0] sb);
    pix_t p;
    rst = r; stall = st; in_valid = v; trans = t; in_sb = sb;
    @(posedge clk);
    if (r) begin
      hist.delete();
      n_act = 0;
    end else if (!st) begin
      hist.push_back('{v, t, sb});
      n_act++;
    end
    @(negedge clk);
    chk_data = 1'b0; exp_v = 1'b0; exp_inv = '0; exp_sb = '0;
    if (n_act == 0) begin
      chk_data = 1'b1;
    end else if (n_act >= LAT) begin
      p = hist[n_act - LAT];
      exp_v = p.v;
      if (p.v) begin
        chk_data = 1'b1;
        exp_inv  = inv_ref(p.t);
        exp_sb   = p.sb;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)), SB_W'($urandom));
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
      tests++;
      if (inv_trans !== 16'h0) begin fails++; $display("FAIL reset_inv: got %h want 0000", inv_trans); end
      tests++;
      if (out_sb !== '0) begin fails++; $display("FAIL reset_sb: got %h want 0", out_sb); end
    end
  endtask

  task automatic test_known_values();
    logic [7:0] tv[8];
    int seen;
    tv = '{8'd128, 8'd255, 8'd200, 8'd65, 8'd64, 8'd1, 8'd0, 8'd65};
    seen = 0;
    for (int i = 0; i < 8 + LAT + 3; i++) begin
      if (i < 8) cycle(1'b0, 1'b0, 1'b1, tv[i], SB_W'(24'hA00000 + i));
      else       cycle(1'b0, 1'b0, 1'b0, 8'($urandom), SB_W'($urandom));
      if (out_valid === 1'b1) seen++;
      tests++;
      if (out_valid !== exp_v) begin fails++; $display("FAIL known_valid cyc %0d: got %0b want %0b", i, out_valid, exp_v); end
      if (chk_data) begin
        tests++;
        if (inv_trans !== exp_inv) begin fails++; $display("FAIL known_inv cyc %0d: got %h want %h", i, inv_trans, exp_inv); end
        tests++;
        if (out_sb !== exp_sb) begin fails++; $display("FAIL known_sb cyc %0d: got %h want %h", i, out_sb, exp_sb); end
      end
    end
    tests++;
    if (seen != 8) begin fails++; $display("FAIL known_count: got %0d want 8", seen); end
    // Table spot-checks of the reference model against hand-derived constants
    tests++;
    if (inv_ref(8'd255) !== 16'h4040 || inv_ref(8'd200) !== 16'h51EB || inv_ref(8'd65) !== 16'hFC0F)
      begin fails++; $display("FAIL model_table: got %h %h %h want 4040 51eb fc0f",
                              inv_ref(8'd255), inv_ref(8'd200), inv_ref(8'd65)); end
  endtask

  task automatic test_streaming();
    int seen;
    int next_idx;
    seen = 0; next_idx = 0;
    for (int i = 0; i < 1000 + LAT + 2; i++) begin
      if (i < 1000) cycle(1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 255)), SB_W'(i));
      else          cycle(1'b0, 1'b0, 1'b0, 8'd0, '0);
      tests++;
      if (out_valid !== exp_v) begin fails++; $display("FAIL stream_valid cyc %0d: got %0b want %0b", i, out_valid, exp_v); end
      if (chk_data && exp_v) begin
        tests++;
        if (inv_trans !== exp_inv) begin fails++; $display("FAIL stream_inv cyc %0d: got %h want %h", i, inv_trans, exp_inv); end
        tests++;
        if (out_sb !== SB_W'(next_idx)) begin fails++; $display("FAIL stream_order cyc %0d: got %0d want %0d", i, out_sb, next_idx); end
      end
      if (out_valid === 1'b1) begin seen++; next_idx++; end
    end
    tests++;
    if (seen != 1000) begin fails++; $display("FAIL stream_count: got %0d want 1000", seen); end
  endtask

  task automatic test_bubbles_stall();
    int stall_left;
    logic st;
    stall_left = 0;
    for (int i = 0; i < 700 + LAT + 3; i++) begin
      if (i < 700) begin
        if (stall_left == 0 && $urandom_range(0, 7) == 0) stall_left = $urandom_range(1, 5);
        st = (stall_left > 0);
        if (stall_left > 0) stall_left--;
        cycle(1'b0, st, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), SB_W'($urandom));
      end else begin
        cycle(1'b0, 1'b0, 1'b0, 8'd0, '0);
      end
      tests++;
      if (out_valid !== exp_v) begin fails++; $display("FAIL bubble_valid cyc %0d: got %0b want %0b", i, out_valid, exp_v); end
      if (chk_data) begin
        tests++;
        if (inv_trans !== exp_inv) begin fails++; $display("FAIL bubble_inv cyc %0d: got %h want %h", i, inv_trans, exp_inv); end
        tests++;
        if (out_sb !== exp_sb) begin fails++; $display("FAIL bubble_sb cyc %0d: got %h want %h", i, out_sb, exp_sb); end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 255)), SB_W'($urandom));
      cycle(1'b1, 1'(pass == 0), 1'b1, 8'd99, SB_W'(24'h123456));
      tests++;
      if (out_valid !== 1'b0 || inv_trans !== 16'h0 || out_sb !== '0) begin
        fails++;
        $display("FAIL midreset_zero pass %0d: got v=%0b inv=%h sb=%h want 0 0 0", pass, out_valid, inv_trans, out_sb);
      end
      for (int i = 0; i < LAT + 4; i++) begin
        if (i == 0) cycle(1'b0, 1'b0, 1'b1, 8'd128, SB_W'(24'hBEEF00 + pass));
        else        cycle(1'b0, 1'b0, 1'b0, 8'($urandom), SB_W'($urandom));
        tests++;
        if (out_valid !== exp_v) begin fails++; $display("FAIL midreset_valid pass %0d cyc %0d: got %0b want %0b", pass, i, out_valid, exp_v); end
        if (chk_data && exp_v) begin
          tests++;
          if (inv_trans !== 16'h8000) begin fails++; $display("FAIL midreset_inv pass %0d: got %h want 8000", pass, inv_trans); end
          tests++;
          if (out_sb !== exp_sb) begin fails++; $display("FAIL midreset_sb pass %0d: got %h want %h", pass, out_sb, exp_sb); end
        end
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0; n_act = 0;
    rst = 1'b1; stall = 1'b0; in_valid = 1'b0; trans = '0; in_sb = '0;
    test_reset();
    test_known_values();
    test_streaming();
    test_bubbles_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inv_transmission_pipe.md
# inv_transmission_pipe

Fully pipelined reciprocal unit producing the inverse transmission 1/t (Q2.14) consumed by the per-channel scene-radiance multiplier. It sits between the transmission estimator, which supplies t as Q0.8, and the radiance stage that computes (Ic − Ac) · (1/t). It accepts one pixel per clock and carries a sideband bus (the per-pixel Ic − Ac values) through an equal-length delay line, so that both arrive at the multiplier aligned.

## Interface
- SB_W, 24: width of the sideband bus delayed alongside the division (3 × 8-bit Ic − Ac).
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  while high, every pipeline register (valid, data, sideband) holds its value.
- in_valid  in  1  t and in_sb carry a pixel this cycle.
- trans  in  8  transmission t, Q0.8 unsigned (t_real = trans/256).
- in_sb  in  SB_W  sideband, delayed unmodified.
- out_valid  out  1  inv_trans/out_sb carry a pixel.
- inv_trans  out  16  1/t, Q2.14 unsigned, truncated, saturated to 16'hFFFF.
- out_sb  out  SB_W  in_sb delayed by the pipeline latency.

## Operation
- Math: inv_trans = floor(2^22 / trans), computed on the 8-bit integer code.
- Saturation: when trans ≤ 64 (t ≤ 0.25, including 0), output 16'hFFFF. A saturate flag is computed at entry and travels with the pixel; the divider result for that pixel is ignored.
- Entry stage (S0): register trans (as divisor D), in_sb, in_valid, sat = (trans ≤ 64), partial remainder R = 64 (9 bits), quotient Q = 0.
- Divide stages S1..S16, stage k resolves quotient bit i = 16 − k (MSB first, restoring):
  - R2 = R << 1 (10 bits)
  - if R2 ≥ D: R ← R2 − D, q_i = 1
  - else: R ← R2, q_i = 0
  - Invariant R < D ≤ 255 keeps R within 9 bits.
- For D ≥ 65, the quotient bits above bit 15 are provably zero, so 16 stages are sufficient.
- Output: inv_trans = sat ? 16'hFFFF : Q, taken from the S16 registers.
- Sideband and valid shift in lockstep with their pixel through S0..S16. Sideband is never modified.
- Data registers load regardless of valid. When out_valid = 0, inv_trans and out_sb are don't-care.
- No backpressure beyond stall. Downstream must accept every out_valid pixel.

## Timing
- Latency: 17 non-stalled rising edges. A pixel accepted on edge N (in_valid = 1, stall = 0) is presented with out_valid = 1 after edge N+16 of the non-stalled edges, i.e. during the cycle following its 17th register stage.
- Throughput: 1 pixel/clock. Bubbles (in_valid = 0) propagate as out_valid = 0 slots in the same relative position.
- Stall: while stall = 1, all registers hold and outputs remain constant. in_valid is not sampled, so upstream must hold or drop its pixel accordingly. Stall cycles add no latency count.
- Reset: on any edge with rst = 1, all valid bits clear and all data/sideband registers clear to 0, giving out_valid = 0, inv_trans = 0, out_sb = 0. rst has priority over stall.
- Reset mid-stream discards every in-flight pixel. The first pixel accepted after rst deasserts emerges 17 edges later, with no stale out_valid in between.
- Back-to-back pixels with different divisors must not interfere; each stage uses only its own D.

## Test plan
- Known values: trans = 128 → 0x8000; 255 → 0x4040 (16448); 200 → 0x51EB (20971); 65 → 0xFC0F (64527). Each arrives exactly 17 edges after acceptance, with its sideband intact.
- Saturation boundary: trans = 64, 1, 0 → 0xFFFF each; trans = 65 → 0xFC0F. Apply back-to-back to check flag alignment.
- Streaming: 1000 random trans values with valid = 1 every cycle, compared against a floor(2^22/t) model with saturation. Sideband = pixel index, which must emerge in order with no gaps.
- Bubbles and stall: random in_valid plus random stall bursts (1–5 cycles). out_valid pattern equals the input pattern shifted by 17 active edges, and outputs stay frozen during stall.
- Reset mid-operation: assert rst for 1 cycle while 10 pixels are in flight (also with stall = 1). out_valid = 0 and all outputs = 0 on the next cycle. No in-flight pixel ever appears, and the next accepted pixel emerges after 17 edges.
